// File: rtl/clock_divider_bank_pkg.sv
// Shared types and constants for the clock divider bank and its per-channel divider.
package clock_divider_bank_pkg;

  localparam int MAX_CH         = 16;
  localparam int DEFAULT_HALF_C = 4;

  // Control state of one channel; counter and half-period widths live in the channel.
  typedef struct packed {
    logic active_en;
    logic clkout;
    logic pend_valid;
    logic pend_en;
  } ch_ctrl_t;

  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_COUNT,
    ACT_TOGGLE,
    ACT_SYNC,
    ACT_WAKE
  } ch_act_t;

  function automatic int ch_sel_width(input int n);
    int nc;
    nc = (n > MAX_CH) ? MAX_CH : n;
    return (nc > 1) ? $clog2(nc) : 1;
  endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: half-period counter, toggling output and a single-entry
// pending configuration slot applied only on a toggle or a sync.
module clock_divider_channel
  import clock_divider_bank_pkg::*;
#(
  parameter int CNT_WIDTH    = 32,
  parameter int DEFAULT_HALF = DEFAULT_HALF_C
) (
  input  logic                 clkin,
  input  logic                 reset,
  input  logic                 wr,
  input  logic [CNT_WIDTH-1:0] wr_half,
  input  logic                 wr_en,
  input  logic                 sync,
  output logic                 clkout,
  output logic                 tick,
  output logic [CNT_WIDTH-1:0] count
);

  localparam logic [CNT_WIDTH-1:0] HALF_RST = CNT_WIDTH'(DEFAULT_HALF);
  localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] counter, counter_nx;
  logic [CNT_WIDTH-1:0] active_half, active_half_nx;
  logic [CNT_WIDTH-1:0] pend_half, pend_half_nx;
  logic [CNT_WIDTH-1:0] reload_half;
  logic [CNT_WIDTH-1:0] eff_half;
  logic                 eff_valid, eff_en;
  ch_ctrl_t             st, st_nx;
  ch_act_t              act;
  logic                 tick_nx;

  assign reload_half = st.pend_valid ? pend_half : active_half;

  // A same-cycle write is folded in ahead of sync so sync picks it up.
  assign eff_valid = wr | st.pend_valid;
  assign eff_half  = wr ? wr_half : pend_half;
  assign eff_en    = wr ? wr_en : st.pend_en;

  always_comb begin
    act = ACT_HOLD;
    if (!st.active_en) begin
      if (wr && wr_en) act = ACT_WAKE;
    end else if (sync) begin
      act = ACT_SYNC;
    end else if (counter == ONE) begin
      act = ACT_TOGGLE;
    end else begin
      act = ACT_COUNT;
    end
  end

  always_comb begin
    counter_nx     = counter;
    active_half_nx = active_half;
    pend_half_nx   = pend_half;
    st_nx          = st;
    tick_nx        = 1'b0;
    case (act)
      ACT_WAKE: begin
        active_half_nx   = wr_half;
        counter_nx       = wr_half;
        st_nx.active_en  = 1'b1;
        st_nx.clkout     = 1'b0;
        st_nx.pend_valid = 1'b0;
      end
      ACT_SYNC: begin
        if (eff_valid) begin
          active_half_nx  = eff_half;
          st_nx.active_en = eff_en;
        end
        counter_nx       = eff_valid ? eff_half : active_half;
        st_nx.clkout     = 1'b0;
        st_nx.pend_valid = 1'b0;
      end
      ACT_TOGGLE: begin
        active_half_nx = reload_half;
        counter_nx     = reload_half;
        st_nx.clkout   = ~st.clkout;
        tick_nx        = 1'b1;
        // A pending disable waits for the falling edge; its half still applies now.
        if (st.pend_valid) begin
          if (st.pend_en) begin
            st_nx.pend_valid = 1'b0;
          end else if (st.clkout) begin
            st_nx.active_en  = 1'b0;
            st_nx.pend_valid = 1'b0;
          end
        end
        if (wr) begin
          st_nx.pend_valid = 1'b1;
          st_nx.pend_en    = wr_en;
          pend_half_nx     = wr_half;
        end
      end
      ACT_COUNT: begin
        counter_nx = counter - ONE;
        if (wr) begin
          st_nx.pend_valid = 1'b1;
          st_nx.pend_en    = wr_en;
          pend_half_nx     = wr_half;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      counter     <= HALF_RST;
      active_half <= HALF_RST;
      st          <= '{active_en: 1'b1, clkout: 1'b0, pend_valid: 1'b0, pend_en: 1'b0};
      tick        <= 1'b0;
    end else begin
      counter     <= counter_nx;
      active_half <= active_half_nx;
      st          <= st_nx;
      tick        <= tick_nx;
    end
  end

  // Payload of the pending slot is qualified by pend_valid, so it needs no reset.
  always_ff @(posedge clkin) begin
    pend_half <= pend_half_nx;
  end

  assign clkout = st.clkout;
  assign count  = counter;

endmodule

// File: rtl/clock_divider_bank.sv
// Bank of NUM_CH independent clock dividers sharing one config bus and one sync strobe.
module clock_divider_bank
  import clock_divider_bank_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int CNT_WIDTH    = 32,
  parameter int DEFAULT_HALF = DEFAULT_HALF_C
) (
  input  logic                              clkin,
  input  logic                              reset,
  input  logic                              cfg_we,
  input  logic [ch_sel_width(NUM_CH)-1:0]   cfg_ch,
  input  logic [CNT_WIDTH-1:0]              cfg_half,
  input  logic                              cfg_en,
  input  logic                              sync,
  output logic                              cfg_err,
  output logic [NUM_CH-1:0]                 clkoutport,
  output logic [NUM_CH-1:0]                 tick,
  output logic [NUM_CH*CNT_WIDTH-1:0]       currentvalue
);

  localparam int              CH_W  = ch_sel_width(NUM_CH);
  localparam logic [CH_W:0]   NCH_L = (CH_W+1)'(NUM_CH);

  logic              bad_cfg;
  logic              cfg_ok;
  logic [NUM_CH-1:0] wr_hit;

  // Zero half-periods would let a counter reach 0, so they are refused here.
  assign bad_cfg = (cfg_half == '0) || ({1'b0, cfg_ch} >= NCH_L);
  assign cfg_ok  = cfg_we && !bad_cfg;

  always_ff @(posedge clkin) begin
    if (reset) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we && bad_cfg;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr_hit[i] = cfg_ok && (cfg_ch == CH_W'(i));

    clock_divider_channel #(
      .CNT_WIDTH    (CNT_WIDTH),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_ch (
      .clkin   (clkin),
      .reset   (reset),
      .wr      (wr_hit[i]),
      .wr_half (cfg_half),
      .wr_en   (cfg_en),
      .sync    (sync),
      .clkout  (clkoutport[i]),
      .tick    (tick[i]),
      .count   (currentvalue[i*CNT_WIDTH +: CNT_WIDTH])
    );
  end

endmodule

// File: doc/clock_divider_bank.md
CLOCK_DIVIDER_BANK -- requirements
Module: clock_divider_bank

Interface
REQ-001 SHALL provide parameter NUM_CH, default 4, number of independent divider channels (1..16).
REQ-002 SHALL provide parameter CNT_WIDTH, default 32, width of each channel's half-period counter.
REQ-003 SHALL provide parameter DEFAULT_HALF, default 4, half-period in clkin cycles loaded at reset (must be >= 1).
REQ-004 clkin  input  1  sole clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 cfg_we  input  1  config write strobe, one-cycle pulse per write.
REQ-007 cfg_ch  input  max(1,clog2(NUM_CH))  target channel of cfg write.
REQ-008 cfg_half  input  CNT_WIDTH  requested half-period in clkin cycles.
REQ-009 cfg_en  input  1  requested channel enable.
REQ-010 sync  input  1  one-cycle pulse; phase-aligns all enabled channels.
REQ-011 cfg_err  output  1  one-cycle pulse: the previous-cycle write was rejected.
REQ-012 clkoutport  output  NUM_CH  divided clock, bit i = channel i.
REQ-013 tick  output  NUM_CH  one-cycle pulse, same cycle as each clkoutport toggle.
REQ-014 currentvalue  output  NUM_CH*CNT_WIDTH  live counter per channel, channel i at bits [i*CNT_WIDTH +: CNT_WIDTH].

Function
REQ-015 Each channel SHALL hold: counter, active_half, active_en, clkout, and a pending slot (pend_valid, pend_half, pend_en).
REQ-016 Enabled channel each cycle: if counter==1, counter<=active_half and clkout toggles, else counter<=counter-1; output period = 2*active_half cycles, 50% duty.
REQ-017 active_half==1 SHALL toggle every cycle (period 2).
REQ-018 A cfg_we with cfg_half==0 or cfg_ch>=NUM_CH SHALL be ignored and cfg_err SHALL pulse the next cycle.
REQ-019 A valid write SHALL overwrite the channel's pending slot; the last write before application wins.
REQ-020 Pending half SHALL apply only at a toggle cycle (counter==1): the reload value is pend_half, not the old active_half; no shortened or stretched half-cycle SHALL occur.
REQ-021 Pending disable (pend_en=0) SHALL apply only at a 1->0 toggle; the channel then freezes with clkout=0, counter=active_half, tick=0.
REQ-022 A valid write with cfg_en=1 to a disabled channel SHALL apply on the next cycle: active_half<=cfg_half, counter<=cfg_half, clkout stays 0, first rising toggle cfg_half cycles later.
REQ-023 sync SHALL, for every enabled channel, apply any pending config, then set counter<=active_half and clkout<=0 with no tick; disabled channels are unaffected.
REQ-024 sync and cfg_we in the same cycle: the write SHALL be taken first, so sync uses it.
REQ-025 A write to a channel landing on that channel's toggle cycle SHALL be deferred to the next toggle.
REQ-026 Counters SHALL never underflow; counter==0 is unreachable.
REQ-027 Channels SHALL be fully independent except for shared cfg bus and sync.

Reset
REQ-028 While reset is high, each channel SHALL load counter=active_half=DEFAULT_HALF, active_en=1, clkout=0, pend_valid=0; tick=0, cfg_err=0.
REQ-029 Reset mid-period SHALL discard pending config; counting restarts the cycle after reset deasserts.

Structure
REQ-030 A shared package SHALL hold the channel-state typedef and DEFAULT_HALF / max-channel constants.
REQ-031 One sub-module, clock_divider_channel, SHALL implement a single channel; the top instantiates NUM_CH copies plus cfg decode and cfg_err.

Verification
REQ-032 Reset, no writes, DEFAULT_HALF=4 -> every clkoutport bit rises 4 cycles after reset, period 8, tick each edge.
REQ-033 Ch1 running half=4, write half=2 mid-high -> current high phase stays 4 cycles, then 2/2 from next toggle.
REQ-034 Write half=0, then cfg_ch=NUM_CH -> each ignored, cfg_err pulses once next cycle, outputs unchanged.
REQ-035 Ch0 disable written while clkout=1 -> high phase completes, falls, frozen at 0, tick silent; re-enable half=3 -> rises 3 cycles later.
REQ-036 Ch0 half=3, ch2 half=5, sync pulse -> both clkout=0 next cycle, rise 3 and 5 cycles later, no tick at sync.
REQ-037 Reset asserted mid-period with pending write -> all channels restart at DEFAULT_HALF, pending discarded.
